dmem_arbiter: RTL

- Sequences and shares the single-port data RAM (8-bit word address, 32-bit data) between two requesters.
- Port 0 is the pipeline MEM stage. Port 1 is the program loader/debug port.
- Round-robin arbitration; one transaction in flight at a time.
- Reads wait a fixed RAM latency, then return data with a one-cycle valid pulse. Port 0 deasserting gnt while requesting is the pipeline stall condition.

---
 rtl/dmem_arbiter_if.sv | 39 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the two data-RAM ports (pipeline MEM stage and loader/debug).
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);

  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  // Requester side: drives requests, receives grants and read responses.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata
  );

  // Arbiter side.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data RAM between the MEM stage (port 0)
// and the loader/debug port (port 1); one read outstanding at a time.
module dmem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  localparam int unsigned CW = $clog2(READ_LAT + 1);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          rd_port_q, rd_port_d;
  logic          p0_rvalid_q, p0_rvalid_d;
  logic          p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          p0_gnt_c, p1_gnt_c;

  // State and response registers; reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rd_port_q    <= 1'b0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rd_port_q    <= rd_port_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  // Arbitration, RAM drive and read-wait sequencing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rd_port_d    = rd_port_q;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    p0_gnt_c     = 1'b0;
    p1_gnt_c     = 1'b0;
    ram_addr     = bus.p0_addr;
    ram_wdata    = bus.p0_wdata;
    ram_wren     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst) begin
          // On a tie the port that did not win last time goes next.
          if (bus.p0_req && (!bus.p1_req || last_grant_q)) begin
            p0_gnt_c = 1'b1;
          end else if (bus.p1_req) begin
            p1_gnt_c = 1'b1;
          end
        end

        if (p0_gnt_c) begin
          ram_wren     = bus.p0_we;
          last_grant_d = 1'b0;
          if (!bus.p0_we) begin
            state_d   = RD_WAIT;
            cnt_d     = CW'(READ_LAT);
            rd_port_d = 1'b0;
          end
        end else if (p1_gnt_c) begin
          ram_addr     = bus.p1_addr;
          ram_wdata    = bus.p1_wdata;
          ram_wren     = bus.p1_we;
          last_grant_d = 1'b1;
          if (!bus.p1_we) begin
            state_d   = RD_WAIT;
            cnt_d     = CW'(READ_LAT);
            rd_port_d = 1'b1;
          end
        end
      end

      RD_WAIT: begin
        // Last wait cycle: ram_q is valid now, capture and pulse rvalid next cycle.
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rd_port_q) begin
            p1_rdata_d  = ram_q;
            p1_rvalid_d = 1'b1;
          end else begin
            p0_rdata_d  = ram_q;
            p0_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.p0_gnt    = p0_gnt_c;
  assign bus.p1_gnt    = p1_gnt_c;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign busy          = (state_q != IDLE);

endmodule
